// File: rtl/router_fsm_nch_if.sv
// ---------------------------------------------------------------------------
// router_fsm_nch_if
// Control bundle between the 1xN router datapath and its control FSM.
//   Datapath -> FSM : pkt_valid, data_in (header address field), fifo_full,
//                     fifo_empty[N], soft_reset[N], parity_done,
//                     low_packet_valid
//   FSM -> datapath : detect_add, lfd_state, ld_state, laf_state, full_state,
//                     rst_int_reg, write_enb_reg, busy, dest_sel[N] (one-hot),
//                     addr_err / wait_timeout (single-cycle pulses)
// modport master : the datapath side that drives status and consumes control
// modport slave  : the FSM
// ---------------------------------------------------------------------------
interface router_fsm_nch_if #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 2
);
  logic                 pkt_valid;
  logic [ADDR_W-1:0]    data_in;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] soft_reset;
  logic                 parity_done;
  logic                 low_packet_valid;

  logic                 detect_add;
  logic                 lfd_state;
  logic                 ld_state;
  logic                 laf_state;
  logic                 full_state;
  logic                 rst_int_reg;
  logic                 write_enb_reg;
  logic                 busy;
  logic [NUM_PORTS-1:0] dest_sel;
  logic                 addr_err;
  logic                 wait_timeout;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
           parity_done, low_packet_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, write_enb_reg, busy, dest_sel, addr_err, wait_timeout
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
           parity_done, low_packet_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, write_enb_reg, busy, dest_sel, addr_err, wait_timeout
  );
endinterface

// File: rtl/router_fsm_nch.sv
// ---------------------------------------------------------------------------
// router_fsm_nch
// Control FSM for a 1xN packet router. Decodes the header address, steers
// header/payload/parity into the selected output FIFO, stalls on FIFO-full,
// drops packets with an illegal address, and drops a packet whose target FIFO
// stays non-empty for TIMEOUT_CYCLES cycles (0 disables the timeout).
// Ports:
//   clock  : rising-edge clock
//   resetn : asynchronous active-low reset
//   bus    : router_fsm_nch_if.slave control bundle (see interface header)
// All outputs are registered Moore decodes of the state.
// ---------------------------------------------------------------------------
module router_fsm_nch #(
  parameter int NUM_PORTS      = 3,
  parameter int ADDR_W         = 2,
  parameter int TIMEOUT_CYCLES = 30
) (
  input  logic            clock,
  input  logic            resetn,
  router_fsm_nch_if.slave bus
);

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    FIFO_FULL_STATE    = 4'd3,
    LOAD_AFTER_FULL    = 4'd4,
    LOAD_PARITY        = 4'd5,
    CHECK_PARITY_ERROR = 4'd6,
    WAIT_TILL_EMPTY    = 4'd7,
    DROP_PACKET        = 4'd8
  } state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [NUM_PORTS-1:0] dest_q;
  logic [NUM_PORTS-1:0] addr_oh;
  logic                 addr_legal, addr_empty, sel_empty, sel_soft_rst, timeout_hit;

  logic detect_add_q, lfd_q, ld_q, laf_q, full_q, rst_int_q, we_q, busy_q;
  logic addr_err_q, wait_timeout_q;

  // An out-of-range address shifts the bit off the top, giving an all-zero
  // vector, so the empty lookup below is safe before legality is known.
  assign addr_oh      = NUM_PORTS'(1) << bus.data_in;
  assign addr_legal   = int'(bus.data_in) < NUM_PORTS;
  assign addr_empty   = |(bus.fifo_empty & addr_oh);
  assign sel_empty    = |(bus.fifo_empty & dest_q);
  assign sel_soft_rst = |(bus.soft_reset & dest_q);
  assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    // NOTE: every path assigns state_d because of this default; without it a
    // missed branch would infer a latch.
    state_d = DECODE_ADDRESS;
    case (state_q)
      DECODE_ADDRESS: begin
        if (!bus.pkt_valid)   state_d = DECODE_ADDRESS;
        else if (!addr_legal) state_d = DROP_PACKET;
        else if (addr_empty)  state_d = LOAD_FIRST_DATA;
        else                  state_d = WAIT_TILL_EMPTY;
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) state_d = LOAD_PARITY;
        else                     state_d = LOAD_DATA;
      end
      FIFO_FULL_STATE: state_d = bus.fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)           state_d = DECODE_ADDRESS;
        else if (bus.low_packet_valid) state_d = LOAD_PARITY;
        else                           state_d = LOAD_DATA;
      end
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      WAIT_TILL_EMPTY: begin
        // Empty is tested first so it wins over a timeout in the same cycle.
        if (sel_empty)        state_d = LOAD_FIRST_DATA;
        else if (timeout_hit) state_d = DROP_PACKET;
        else                  state_d = WAIT_TILL_EMPTY;
      end
      DROP_PACKET: state_d = bus.pkt_valid ? DROP_PACKET : DECODE_ADDRESS;
      default:     state_d = DECODE_ADDRESS;
    endcase
    // Soft reset of the selected channel aborts the packet. DROP is exempt:
    // after a timeout dest_q still names the channel being abandoned.
    if (sel_soft_rst && state_q != DECODE_ADDRESS && state_q != DROP_PACKET)
      state_d = DECODE_ADDRESS;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= DECODE_ADDRESS;
      dest_q         <= '0;
      cnt_q          <= '0;
      addr_err_q     <= 1'b0;
      wait_timeout_q <= 1'b0;
      detect_add_q   <= 1'b1;
      lfd_q          <= 1'b0;
      ld_q           <= 1'b0;
      laf_q          <= 1'b0;
      full_q         <= 1'b0;
      rst_int_q      <= 1'b0;
      we_q           <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_d == DECODE_ADDRESS)
        dest_q <= '0;
      else if (state_q == DECODE_ADDRESS &&
               (state_d == LOAD_FIRST_DATA || state_d == WAIT_TILL_EMPTY))
        dest_q <= addr_oh;

      // Counts cycles spent in WAIT; any other transition clears it, so each
      // entry starts from zero. Saturates rather than wrapping.
      if (state_q == WAIT_TILL_EMPTY && state_d == WAIT_TILL_EMPTY)
        cnt_q <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      else
        cnt_q <= '0;

      addr_err_q     <= (state_q == DECODE_ADDRESS)  && (state_d == DROP_PACKET);
      wait_timeout_q <= (state_q == WAIT_TILL_EMPTY) && (state_d == DROP_PACKET);

      // Decoding state_d here makes these flops track the state register.
      detect_add_q <= state_d == DECODE_ADDRESS;
      lfd_q        <= state_d == LOAD_FIRST_DATA;
      ld_q         <= state_d == LOAD_DATA;
      laf_q        <= state_d == LOAD_AFTER_FULL;
      full_q       <= state_d == FIFO_FULL_STATE;
      rst_int_q    <= state_d == CHECK_PARITY_ERROR;
      we_q         <= state_d inside {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL};
      busy_q       <= state_d inside {LOAD_FIRST_DATA, WAIT_TILL_EMPTY, FIFO_FULL_STATE,
                                      LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR};
    end
  end

  assign bus.detect_add    = detect_add_q;
  assign bus.lfd_state     = lfd_q;
  assign bus.ld_state      = ld_q;
  assign bus.laf_state     = laf_q;
  assign bus.full_state    = full_q;
  assign bus.rst_int_reg   = rst_int_q;
  assign bus.write_enb_reg = we_q;
  assign bus.busy          = busy_q;
  assign bus.dest_sel      = dest_q;
  assign bus.addr_err      = addr_err_q;
  assign bus.wait_timeout  = wait_timeout_q;

endmodule
